// File: rtl/fetch_pc_unit_pkg.sv
// Shared decode constants, in-flight branch entry type and immediate helpers
// for the fetch/PC redirect unit.
package fetch_pc_unit_pkg;

    localparam logic [6:0] B_type    = 7'b1100011;
    localparam logic [6:0] J_type    = 7'b1101111;
    localparam logic [6:0] JALR_type = 7'b1100111;

    // Width of the address fields stored per tracked entry.
    localparam int unsigned TrackXlen = 32;

    typedef struct packed {
        logic                 pred_taken;
        logic [TrackXlen-1:0] pred_target;
        logic [TrackXlen-1:0] fallback;
    } branch_track_t;

    // Sign-extended B-type byte offset (imm[12:1] << 1).
    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // Sign-extended J-type byte offset (imm[20:1] << 1).
    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_branch_track_fifo.sv
// Circular queue of in-flight control-flow entries; clear wins over push/pop,
// and a push at full occupancy is accepted when a pop frees the slot.
module branch_track_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter type         elem_t = logic
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  elem_t                  wdata,
    output elem_t                  head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    elem_t           mem_q [DEPTH];
    logic [PtrW-1:0] head_q, tail_q;
    logic [PtrW:0]   count_q;
    logic            do_push, do_pop;

    assign full    = (count_q == (PtrW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[head_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (clear) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + 1'b1;
            if (do_pop)  head_q <= head_q + 1'b1;
            count_q <= count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
        end
    end

    // Payload storage needs no reset: the count alone says what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[tail_q] <= wdata;
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC generation with static B/J redirect and an in-order in-flight branch queue.
// Optional FETCH_PERF_CNT_EN adds saturating branch/mispredict counters.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     TRACK_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [31:0]                  data,
    input  logic                         prediction,
    input  logic                         pc_write,
    input  logic                         resolve_valid,
    input  logic                         resolve_taken,
    input  logic [XLEN-1:0]              resolve_target,
    output logic [XLEN-1:0]              address,
    output logic                         if_id_flush,
    output logic                         id_ex_flush,
    output logic                         fetch_stall,
    output logic [$clog2(TRACK_DEPTH):0] track_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                  branch_count,
    output logic [31:0]                  mispredict_count
`endif
);

    logic [XLEN-1:0] pc_q, pc_d, pc_plus4, offset, pc_plus_off;
    logic [XLEN-1:0] head_target, head_fallback;
    logic            is_b, is_j, is_jalr, is_cf;
    logic            q_full, q_empty, resolve_act, mispredict, push;
    logic            empty_resolve_err_q;
    branch_track_t   entry_new, entry_head;

    assign is_b    = (data[6:0] == B_type);
    assign is_j    = (data[6:0] == J_type);
    assign is_jalr = (data[6:0] == JALR_type);
    assign is_cf   = is_b || is_j || is_jalr;

    assign offset      = is_j ? XLEN'($signed(imm_j(data))) : XLEN'($signed(imm_b(data)));
    assign pc_plus4    = pc_q + XLEN'(4);
    assign pc_plus_off = pc_q + offset;

    assign entry_new.pred_taken  = is_j || (is_b && prediction);
    assign entry_new.pred_target = TrackXlen'(is_jalr ? pc_plus4 : pc_plus_off);
    assign entry_new.fallback    = TrackXlen'(pc_plus4);

    assign head_target   = XLEN'(entry_head.pred_target);
    assign head_fallback = XLEN'(entry_head.fallback);

    assign resolve_act = resolve_valid && !q_empty;
    assign mispredict  = resolve_act &&
                         ((resolve_taken != entry_head.pred_taken) ||
                          (resolve_taken && (resolve_target != head_target)));

    // A correct resolve frees a slot this cycle, so a full queue need not stall.
    assign fetch_stall = q_full && is_cf && !(resolve_act && !mispredict);
    assign push        = is_cf && pc_write && !fetch_stall && !mispredict;

    assign if_id_flush = mispredict;
    assign id_ex_flush = mispredict;
    assign address     = pc_q;

    branch_track_fifo #(
        .DEPTH  (TRACK_DEPTH),
        .elem_t (branch_track_t)
    ) u_track (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (resolve_act),
        .clear   (mispredict),
        .wdata   (entry_new),
        .head    (entry_head),
        .full    (q_full),
        .empty   (q_empty),
        .count   (track_count)
    );

    always_comb begin
        pc_d = pc_q;
        if (mispredict) begin
            pc_d = resolve_taken ? resolve_target : head_fallback;
        end else if (!pc_write || fetch_stall) begin
            pc_d = pc_q;
        end else if ((is_b && prediction) || is_j) begin
            pc_d = pc_plus_off;
        end else begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q                <= RESET_PC;
            empty_resolve_err_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (resolve_valid && q_empty) empty_resolve_err_q <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] branch_count_q, mispredict_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (resolve_act && (branch_count_q != '1)) branch_count_q <= branch_count_q + 1'b1;
            if (mispredict && (mispredict_count_q != '1)) begin
                mispredict_count_q <= mispredict_count_q + 1'b1;
            end
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed + randomized bench for fetch_pc_unit against a queue-based reference model.
module tb_fetch_pc_unit;

    localparam int Depth = 4;

    typedef struct {
        bit          taken;
        logic [31:0] tgt;
        logic [31:0] fb;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data = 32'h13;
    logic        prediction = 1'b0;
    logic        pc_write = 1'b1;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic [31:0] resolve_target = '0;
    logic [31:0] address;
    logic        if_id_flush, id_ex_flush, fetch_stall;
    logic [2:0]  track_count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] branch_count, mispredict_count;
`endif

    fetch_pc_unit #(
        .XLEN        (32),
        .TRACK_DEPTH (Depth),
        .RESET_PC    (32'h0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .data           (data),
        .prediction     (prediction),
        .pc_write       (pc_write),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .resolve_target (resolve_target),
        .address        (address),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .fetch_stall    (fetch_stall),
        .track_count    (track_count)
`ifdef FETCH_PERF_CNT_EN
        ,
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    ent_t        m_q[$];
    bit          m_err;
    int unsigned m_bcnt, m_mcnt;
    logic        seen_flush, seen_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input int off);
        logic [12:0] i;
        i = off[12:0];
        return {i[12], i[10:5], 5'd0, 5'd0, 3'd0, i[4:1], i[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int off);
        logic [20:0] i;
        i = off[20:0];
        return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'h6f};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; data = 32'h13; pc_write = 1'b1; resolve_valid = 1'b0;
        #2;
        chk("rst_addr", 64'(address), 64'h0);
        chk("rst_count", 64'(track_count), 64'h0);
        chk("rst_flush", 64'({if_id_flush, id_ex_flush, fetch_stall}), 64'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_pc = 32'h0; m_q.delete(); m_err = 0; m_bcnt = 0; m_mcnt = 0;
    endtask

    // kind: 0 NOP, 1 B, 2 J, 3 JALR. Called at posedge+1; returns at next posedge+1.
    task automatic step(input int kind, input int off, input bit pred, input bit pcw,
                        input bit rv, input bit rt, input logic [31:0] rtgt);
        bit          act, mis, full, cf, stall, taken_fetch;
        logic [31:0] npc;
        ent_t        e;
        case (kind)
            1:       data = enc_b(off);
            2:       data = enc_j(off);
            3:       data = 32'h000080e7;
            default: data = 32'h00000013;
        endcase
        prediction = pred; pc_write = pcw;
        resolve_valid = rv; resolve_taken = rt; resolve_target = rtgt;
        cf    = (kind != 0);
        act   = rv && (m_q.size() > 0);
        mis   = act && ((rt != m_q[0].taken) || (rt && rtgt != m_q[0].tgt));
        full  = (m_q.size() == Depth);
        stall = full && cf && !(act && !mis);
        taken_fetch = (kind == 2) || (kind == 1 && pred);
        #3;
        seen_flush = if_id_flush; seen_stall = fetch_stall;
        chk("addr", 64'(address), 64'(m_pc));
        chk("count", 64'(track_count), 64'(m_q.size()));
        chk("if_id_flush", 64'(if_id_flush), 64'(mis));
        chk("id_ex_flush", 64'(id_ex_flush), 64'(mis));
        chk("fetch_stall", 64'(fetch_stall), 64'(stall));
        chk("err_bit", 64'(dut.empty_resolve_err_q), 64'(m_err));
`ifdef FETCH_PERF_CNT_EN
        chk("branch_count", 64'(branch_count), 64'(m_bcnt));
        chk("mispredict_count", 64'(mispredict_count), 64'(m_mcnt));
`endif
        if (mis)                  npc = rt ? rtgt : m_q[0].fb;
        else if (!pcw || stall)   npc = m_pc;
        else if (taken_fetch)     npc = m_pc + 32'(off);
        else                      npc = m_pc + 32'd4;
        e.taken = taken_fetch;
        e.tgt   = (kind == 3) ? m_pc + 32'd4 : m_pc + 32'(off);
        e.fb    = m_pc + 32'd4;
        if (rv && m_q.size() == 0) m_err = 1;
        if (act) m_bcnt++;
        if (mis) m_mcnt++;
        if (mis) m_q.delete();
        else begin
            if (act) void'(m_q.pop_front());
            if (cf && pcw && !stall) m_q.push_back(e);
        end
        @(posedge clk); #1;
        m_pc = npc;
    endtask

    task automatic nop();
        step(0, 0, 0, 1, 0, 0, 32'h0);
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();

        // Sequential NOPs
        nop(); chk("nop_addr1", 64'(address), 64'h4);
        nop(); chk("nop_addr2", 64'(address), 64'h8);
        nop(); chk("nop_addr3", 64'(address), 64'hc);
        nop();
        // Predicted-taken B resolved correctly
        step(1, 32'h20, 1, 1, 0, 0, 32'h0);
        chk("b_taken_addr", 64'(address), 64'h30);
        chk("b_taken_count", 64'(track_count), 64'h1);
        nop();
        step(0, 0, 0, 1, 1, 1, 32'h30);
        chk("b_ok_flush", 64'(seen_flush), 64'h0);
        chk("b_ok_count", 64'(track_count), 64'h0);

        // Predicted-taken B mispredicts while pc_write is low
        do_reset();
        repeat (4) nop();
        step(1, 32'h20, 1, 1, 0, 0, 32'h0);
        nop();
        step(0, 0, 0, 0, 1, 0, 32'h0);
        chk("b_mis_flush", 64'(seen_flush), 64'h1);
        chk("b_mis_addr", 64'(address), 64'h14);
        chk("b_mis_count", 64'(track_count), 64'h0);
        nop();
        chk("b_mis_flush_drop", 64'(seen_flush), 64'h0);

        // JALR redirect
        do_reset();
        repeat (16) nop();
        step(3, 0, 0, 1, 0, 0, 32'h0);
        chk("jalr_addr", 64'(address), 64'h44);
        step(0, 0, 0, 1, 1, 1, 32'h100);
        chk("jalr_flush", 64'(seen_flush), 64'h1);
        chk("jalr_addr2", 64'(address), 64'h100);

        // Full queue stall and same-cycle release
        do_reset();
        repeat (4) step(1, 8, 0, 1, 0, 0, 32'h0);
        step(1, 8, 0, 1, 0, 0, 32'h0);
        chk("stall_seen", 64'(seen_stall), 64'h1);
        chk("stall_addr", 64'(address), 64'h10);
        step(1, 8, 0, 1, 1, 0, 32'h0);
        chk("stall_release", 64'(seen_stall), 64'h0);
        chk("stall_rel_addr", 64'(address), 64'h14);
        chk("stall_rel_count", 64'(track_count), 64'h4);

        // Resolve on empty queue
        do_reset();
        step(0, 0, 0, 1, 1, 1, 32'h80);
        chk("empty_flush", 64'(seen_flush), 64'h0);
        chk("empty_addr", 64'(address), 64'h4);
        chk("empty_err", 64'(dut.empty_resolve_err_q), 64'h1);

        // Three resolves, one mispredict
        do_reset();
        repeat (3) step(1, 8, 0, 1, 0, 0, 32'h0);
        step(0, 0, 0, 1, 1, 0, 32'h0);
        step(0, 0, 0, 1, 1, 0, 32'h0);
        step(0, 0, 0, 1, 1, 1, 32'h200);
        chk("perf_addr", 64'(address), 64'h200);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_bcnt", 64'(branch_count), 64'd3);
        chk("perf_mcnt", 64'(mispredict_count), 64'd1);
`endif

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int          kind, off;
            bit          pred, pcw, rv, rt;
            logic [31:0] rtgt;
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                continue;
            end
            kind = $urandom_range(0, 5) > 3 ? 0 : $urandom_range(0, 3);
            off  = (int'($urandom_range(0, 2047)) - 1024) * 2;
            pred = $urandom_range(0, 1);
            pcw  = $urandom_range(0, 7) != 0;
            rv   = $urandom_range(0, 2) == 0;
            rt   = $urandom_range(0, 1);
            rtgt = $urandom;
            if (m_q.size() > 0 && $urandom_range(0, 9) < 7) begin
                rt   = m_q[0].taken;
                rtgt = m_q[0].tgt;
            end
            step(kind, off, pred, pcw, rv, rt, rtgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
